// File: rtl/mure_pkg.sv
// Shared types for the retired-instruction trace path: fifo entry layout and
// the window sequencer state encoding.
package mure_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] insn;
  } fifo_entry_s;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN_SHIFT,
    DRAIN_WAIT
  } seq_state_e;

  localparam int unsigned STALL_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/te_window_shreg.sv
// Three-slot window shift register: w0 newest, w2 oldest. A shift loads either
// the incoming entry or an all-zero bubble; clear wipes every slot.
module te_window_shreg
  import mure_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        shift_i,
  input  logic        bubble_i,
  input  logic        clear_i,
  input  fifo_entry_s entry_i,
  output fifo_entry_s w0_o,
  output fifo_entry_s w1_o,
  output fifo_entry_s w2_o
);

  fifo_entry_s w0_q, w1_q, w2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w0_q <= '0;
      w1_q <= '0;
      w2_q <= '0;
    end else if (clear_i) begin
      w0_q <= '0;
      w1_q <= '0;
      w2_q <= '0;
    end else if (shift_i) begin
      w0_q <= bubble_i ? fifo_entry_s'('0) : entry_i;
      w1_q <= w0_q;
      w2_q <= w1_q;
    end
  end

  assign w0_o = w0_q;
  assign w1_o = w1_q;
  assign w2_o = w2_q;

endmodule

// File: rtl/te_window_sequencer.sv
// Feeds the itype detector a lc/tc/nc window built from retired fifo entries,
// presenting each complete window once and draining with bubbles at end of trace.
module te_window_sequencer
  import mure_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = STALL_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W         = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  fifo_entry_s entry_i,
  input  logic        entry_valid_i,
  output logic        entry_ready_o,
  input  logic        flush_i,
  output fifo_entry_s lc_fifo_entry_o,
  output fifo_entry_s tc_fifo_entry_o,
  output fifo_entry_s nc_fifo_entry_o,
  output logic        window_valid_o,
  input  logic        window_ready_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    (STALL_TIMEOUT == 0) ? '0 : CNT_W'(STALL_TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fifo_entry_s w0, w1, w2;

  logic accept, consume, shift, bubble, clear, idle, fire, new_valid;

  te_window_shreg u_shreg (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .shift_i  (shift),
    .bubble_i (bubble),
    .clear_i  (clear),
    .entry_i  (entry_i),
    .w0_o     (w0),
    .w1_o     (w1),
    .w2_o     (w2)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    entry_ready_o = (state_q inside {IDLE, FILL, RUN}) && !flush_i &&
                    (!pend_q || window_ready_i);
    accept        = entry_valid_i && entry_ready_o;
    consume       = pend_q && window_ready_i;
    bubble        = (state_q == DRAIN_SHIFT);
    shift         = accept || (bubble && !pend_q);
    new_valid     = bubble ? 1'b0 : entry_i.valid;
    idle          = !accept && !pend_q;
    fire          = (STALL_TIMEOUT != 0) && (state_q == RUN) && !flush_i &&
                    idle && (cnt_q == CNT_LAST);
    clear         = 1'b0;
    state_d       = state_q;

    // Post-shift w1 is the current w0, so it decides whether a window forms.
    pend_d = pend_q;
    if (shift && w0.valid && (new_valid || bubble)) begin
      pend_d = 1'b1;
    end else if (consume) begin
      pend_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = FILL;
      end
      FILL: begin
        if (flush_i)     state_d = DRAIN_SHIFT;
        else if (accept) state_d = RUN;
      end
      RUN: begin
        if (flush_i || fire) state_d = DRAIN_SHIFT;
      end
      DRAIN_SHIFT: begin
        if (!pend_q) begin
          if (w0.valid) begin
            state_d = DRAIN_WAIT;
          end else if (!w1.valid) begin
            // Nothing real left to present; avoid bubbling forever.
            clear   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN_WAIT: begin
        if (consume) begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if ((state_d != RUN) || accept || (STALL_TIMEOUT == 0)) begin
      cnt_d = '0;
    end else if (idle) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign lc_fifo_entry_o = w2;
  assign tc_fifo_entry_o = w1;
  assign nc_fifo_entry_o = w0;
  assign window_valid_o  = pend_q;
  assign busy_o          = (state_q != IDLE);
  assign timeout_o       = fire;

endmodule

// File: tb/tb_te_window_sequencer.sv
// Directed bench for te_window_sequencer: expected windows are queued by the
// stimulus and compared by an independent monitor at each window consume.
module tb_te_window_sequencer;
  import mure_pkg::*;

  typedef struct packed {
    fifo_entry_s lc;
    fifo_entry_s tc;
    fifo_entry_s nc;
  } win_t;

  logic        clk, rst_n;
  fifo_entry_s e, lc, tc, nc;
  logic        ev, er, fl, wv, wr, busy, to;

  fifo_entry_s b_e, b_lc, b_tc, b_nc;
  logic        b_ev, b_er, b_fl, b_wv, b_wr, b_busy, b_to;

  int checks = 0;
  int errors = 0;
  int a_to_cnt = 0;
  int b_to_cnt = 0;
  int first_to;

  win_t        exp_q[$];
  win_t        mon_cur;
  fifo_entry_s NONE;

  te_window_sequencer #(.STALL_TIMEOUT(4)) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .entry_i         (e),
    .entry_valid_i   (ev),
    .entry_ready_o   (er),
    .flush_i         (fl),
    .lc_fifo_entry_o (lc),
    .tc_fifo_entry_o (tc),
    .nc_fifo_entry_o (nc),
    .window_valid_o  (wv),
    .window_ready_i  (wr),
    .busy_o          (busy),
    .timeout_o       (to)
  );

  te_window_sequencer #(.STALL_TIMEOUT(0)) u_dut_nto (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .entry_i         (b_e),
    .entry_valid_i   (b_ev),
    .entry_ready_o   (b_er),
    .flush_i         (b_fl),
    .lc_fifo_entry_o (b_lc),
    .tc_fifo_entry_o (b_tc),
    .nc_fifo_entry_o (b_nc),
    .window_valid_o  (b_wv),
    .window_ready_i  (b_wr),
    .busy_o          (b_busy),
    .timeout_o       (b_to)
  );

  always #5 clk = ~clk;

  function automatic fifo_entry_s mk(input logic [31:0] pc);
    fifo_entry_s r;
    r.valid = 1'b1;
    r.pc    = pc;
    r.insn  = pc ^ 32'hA5A5_0000;
    return r;
  endfunction

  function automatic win_t mkw(input fifo_entry_s l, input fifo_entry_s t, input fifo_entry_s n);
    win_t r;
    r.lc = l;
    r.tc = t;
    r.nc = n;
    return r;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (to)   a_to_cnt++;
    if (b_to) b_to_cnt++;
  end

  always @(negedge clk) begin
    if (wv && wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got lc=%h tc=%h nc=%h expected none (t=%0t)",
                 lc, tc, nc, $time);
      end else begin
        mon_cur = exp_q.pop_front();
        chk("win_lc", lc, mon_cur.lc);
        chk("win_tc", tc, mon_cur.tc);
        chk("win_nc", nc, mon_cur.nc);
      end
    end
  end

  initial begin
    NONE = '0;
    clk = 1'b0; rst_n = 1'b0;
    e = '0; ev = 1'b0; fl = 1'b0; wr = 1'b1;
    b_e = '0; b_ev = 1'b0; b_fl = 1'b0; b_wr = 1'b1;

    @(negedge clk);
    chk("rst_ready", er, 1'b1);
    chk("rst_wv", wv, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", to, 1'b0);
    chk("rst_lc", lc, NONE);
    chk("rst_tc", tc, NONE);
    chk("rst_nc", nc, NONE);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // 1: streaming
    ev = 1'b1; e = mk(32'h100);
    step();
    @(negedge clk);
    chk("fill_no_window", wv, 1'b0);
    chk("fill_busy", busy, 1'b1);
    e = mk(32'h104);
    exp_q.push_back(mkw(NONE, mk(32'h100), mk(32'h104)));
    step();
    @(negedge clk);
    chk("latency1", wv, 1'b1);
    e = mk(32'h108);
    exp_q.push_back(mkw(mk(32'h100), mk(32'h104), mk(32'h108)));
    step();

    // 2: backpressure
    wr = 1'b0; e = mk(32'h10C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", er, 1'b0);
      chk("bp_lc", lc, mk(32'h100));
      chk("bp_tc", tc, mk(32'h104));
      chk("bp_nc", nc, mk(32'h108));
      step();
    end
    wr = 1'b1;
    exp_q.push_back(mkw(mk(32'h104), mk(32'h108), mk(32'h10C)));
    step();

    // 3: flush from RUN with a window pending
    e = mk(32'h200);
    exp_q.push_back(mkw(mk(32'h108), mk(32'h10C), mk(32'h200)));
    step();
    e = mk(32'h204);
    exp_q.push_back(mkw(mk(32'h10C), mk(32'h200), mk(32'h204)));
    step();
    e = mk(32'h2FF); fl = 1'b1;
    exp_q.push_back(mkw(mk(32'h200), mk(32'h204), NONE));
    @(negedge clk);
    chk("flush_wins", er, 1'b0);
    repeat (5) step();
    @(negedge clk);
    chk("drain_idle_busy", busy, 1'b0);
    chk("drain_idle_wv", wv, 1'b0);
    chk("drain_idle_lc", lc, NONE);
    chk("drain_idle_tc", tc, NONE);
    chk("drain_idle_nc", nc, NONE);
    chk("idle_flush_ready", er, 1'b0);
    ev = 1'b0; fl = 1'b0;
    #1;
    chk("idle_ready", er, 1'b1);
    step();

    // 4: flush from FILL
    ev = 1'b1; e = mk(32'h300);
    step();
    ev = 1'b0; fl = 1'b1;
    exp_q.push_back(mkw(NONE, mk(32'h300), NONE));
    repeat (4) step();
    fl = 1'b0;
    step();
    @(negedge clk);
    chk("fill_drain_busy", busy, 1'b0);

    // 5: stall timeout (STALL_TIMEOUT=4)
    step();
    ev = 1'b1; e = mk(32'h400);
    step();
    e = mk(32'h404);
    exp_q.push_back(mkw(NONE, mk(32'h400), mk(32'h404)));
    step();
    ev = 1'b0;
    exp_q.push_back(mkw(mk(32'h400), mk(32'h404), NONE));
    first_to = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (to && first_to == 0) first_to = n;
      step();
    end
    chk("timeout_cycle", 65'(first_to), 65'd5);
    @(negedge clk);
    chk("timeout_drain_busy", busy, 1'b0);

    // 5b: timeout disabled
    b_ev = 1'b1; b_e = mk(32'h600);
    step();
    b_e = mk(32'h604);
    step();
    b_ev = 1'b0;
    repeat (100) step();
    @(negedge clk);
    chk("nto_pulses", 65'(b_to_cnt), 65'd0);
    chk("nto_busy", b_busy, 1'b1);
    chk("nto_wv", b_wv, 1'b0);

    // 6: reset during DRAIN_WAIT with a window pending
    step();
    ev = 1'b1; e = mk(32'h500);
    step();
    e = mk(32'h504);
    exp_q.push_back(mkw(NONE, mk(32'h500), mk(32'h504)));
    step();
    ev = 1'b0; fl = 1'b1;
    step();
    wr = 1'b0;
    step();
    @(negedge clk);
    chk("pre_rst_wv", wv, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0; fl = 1'b0;
    #1;
    chk("async_rst_wv", wv, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_lc", lc, NONE);
    chk("async_rst_tc", tc, NONE);
    chk("async_rst_ready", er, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1; wr = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("post_rst_wv", wv, 1'b0);
    chk("post_rst_ready", er, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    chk("timeout_pulses", 65'(a_to_cnt), 65'd1);
    chk("queue_empty", 65'(exp_q.size()), 65'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
